// File: rtl/soc_system_flags_evt_ctrl_if.sv
// Avalon-MM slave bus bundle for the flag event controller.
// Master drives address/strobes/data, slave returns registered readdata.
interface soc_system_flags_evt_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_flags_evt_ctrl.sv
// Flag synchroniser, sticky edge capture and masked level irq for the HPS.
// Register map: 0 DATA, 1 MASK, 2 EDGE (W1C), 3 MODE (2 bits per flag).
module soc_system_flags_evt_ctrl #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_flags_evt_ctrl_if.slave avs,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   det;
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   mask_next;
    logic [WIDTH-1:0]   edge_q;
    logic [WIDTH-1:0]   edge_next;
    logic [WIDTH-1:0]   w1c;
    logic [2*WIDTH-1:0] mode_q;
    logic [2*WIDTH-1:0] mode_next;
    logic [31:0]        read_mux;
    logic               wr_mask;
    logic               wr_edge;
    logic               wr_mode;
    logic               unused_wdata;

    assign sync = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^avs.writedata[31:2*WIDTH];

    // Metastability chain on the raw flags plus a one-clk history for edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync;
        end
    end

    // Per-flag edge detection selected by the 2-bit mode field.
    always_comb begin
        rise = sync & ~prev_q;
        fall = ~sync & prev_q;
        det  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_q[2*i +: 2])
                2'b01:   det[i] = rise[i];
                2'b10:   det[i] = fall[i];
                2'b11:   det[i] = rise[i] | fall[i];
                default: det[i] = 1'b0;
            endcase
        end
    end

    // Next-state of the control registers; a new detection beats a W1C.
    always_comb begin
        wr_mask   = avs.write && (avs.address == ADDR_MASK);
        wr_edge   = avs.write && (avs.address == ADDR_EDGE);
        wr_mode   = avs.write && (avs.address == ADDR_MODE);
        mask_next = wr_mask ? avs.writedata[WIDTH-1:0] : mask_q;
        mode_next = wr_mode ? avs.writedata[2*WIDTH-1:0] : mode_q;
        w1c       = wr_edge ? avs.writedata[WIDTH-1:0] : '0;
        edge_next = (edge_q & ~w1c) | det;
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        read_mux = '0;
        unique case (avs.address)
            ADDR_DATA: read_mux[WIDTH-1:0]   = sync;
            ADDR_MASK: read_mux[WIDTH-1:0]   = mask_q;
            ADDR_EDGE: read_mux[WIDTH-1:0]   = edge_q;
            ADDR_MODE: read_mux[2*WIDTH-1:0] = mode_q;
        endcase
    end

    // Register state, registered irq and one-cycle-latency readdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q       <= '0;
            edge_q       <= '0;
            mode_q       <= '0;
            irq          <= 1'b0;
            avs.readdata <= '0;
        end else begin
            mask_q       <= mask_next;
            edge_q       <= edge_next;
            mode_q       <= mode_next;
            irq          <= |(edge_next & mask_next);
            avs.readdata <= avs.read ? read_mux : '0;
        end
    end

endmodule

// File: tb/tb_soc_system_flags_evt_ctrl.sv
// Randomised scoreboard bench for soc_system_flags_evt_ctrl.
// Reference model predicts readdata/irq per clk; monitor compares on negedge.
module tb_soc_system_flags_evt_ctrl;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] in_port = '0;
    logic         irq;

    soc_system_flags_evt_ctrl_if bus();

    soc_system_flags_evt_ctrl #(
        .WIDTH(W),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs(bus),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model state
    logic [W-1:0]   hist[$];
    logic [W-1:0]   m_prev;
    logic [W-1:0]   m_mask;
    logic [W-1:0]   m_edge;
    logic [2*W-1:0] m_mode;
    logic           m_irq;
    logic [31:0]    exp_q[$];
    logic [W-1:0]   s_m;
    logic [W-1:0]   d_m;
    logic [W-1:0]   nm;
    logic [W-1:0]   ne;
    logic [2*W-1:0] nmo;
    logic [31:0]    rv;
    logic [31:0]    mexp;

    function automatic logic [W-1:0] detect(input logic [W-1:0] s,
                                            input logic [W-1:0] p,
                                            input logic [2*W-1:0] mode);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) begin
            int md;
            md = int'(mode[2*i +: 2]);
            if (md == 1)      d[i] = s[i] && !p[i];
            else if (md == 2) d[i] = !s[i] && p[i];
            else if (md == 3) d[i] = s[i] != p[i];
        end
        return d;
    endfunction

    // Model: hist holds the last S samples of in_port, oldest is the synced value.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            repeat (S) hist.push_back('0);
            m_prev = '0;
            m_mask = '0;
            m_edge = '0;
            m_mode = '0;
            m_irq  = 1'b0;
            exp_q.delete();
        end else begin
            s_m = hist[S-1];
            d_m = detect(s_m, m_prev, m_mode);
            rv = 0;
            case (bus.address)
                2'd0: rv[W-1:0]   = s_m;
                2'd1: rv[W-1:0]   = m_mask;
                2'd2: rv[W-1:0]   = m_edge;
                default: rv[2*W-1:0] = m_mode;
            endcase
            exp_q.push_back(bus.read ? rv : 32'h0);
            nm  = m_mask;
            ne  = m_edge;
            nmo = m_mode;
            if (bus.write) begin
                case (bus.address)
                    2'd1: nm = bus.writedata[W-1:0];
                    2'd2: ne = ne & ~bus.writedata[W-1:0];
                    2'd3: nmo = bus.writedata[2*W-1:0];
                    default: ;
                endcase
            end
            ne = ne | d_m;
            m_mask = nm;
            m_edge = ne;
            m_mode = nmo;
            m_irq  = |(ne & nm);
            m_prev = s_m;
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
    end

    // Monitor: every clk out of reset, compare readdata and irq.
    always @(negedge clk) begin
        if (reset_n) begin
            mexp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            chk("sb_readdata", bus.readdata, mexp);
            chk("sb_irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] d);
        @(negedge clk);
        bus.read = r;
        bus.write = w;
        bus.address = a;
        bus.writedata = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    task automatic set_in(input logic [W-1:0] v);
        idle();
        in_port = v;
    endtask

    task automatic rd_expect(input string name, input logic [1:0] a,
                             input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'h0);
        @(posedge clk);
        #1;
        chk(name, bus.readdata, exp);
    endtask

    int n;

    initial begin
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = 2'd0;
        bus.writedata = 32'h0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        rd_expect("reset_mask", 2'd1, 32'h0);
        rd_expect("reset_edge", 2'd2, 32'h0);
        rd_expect("reset_mode", 2'd3, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Rising-edge latency to irq
        wr(2'd3, 32'h55);
        wr(2'd1, 32'h1);
        idle();
        set_in(4'h1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!irq && n < 10);
        // in_port changes between edges: S+1 edges, S+2 clk incl. that cycle
        chk("irq_latency", n, S + 1);
        rd_expect("edge_after_rise", 2'd2, 32'h1);

        // W1C on the same clk as a new rise on flag0
        set_in(4'h0);
        repeat (S + 1) idle();
        set_in(4'h1);
        repeat (S - 1) idle();
        wr(2'd2, 32'h1);
        rd_expect("race_edge", 2'd2, 32'h1);
        chk("race_irq", {31'b0, irq}, 32'h1);

        // Both-edge capture while masked, then unmask
        wr(2'd1, 32'h0);
        set_in(4'h0);
        repeat (S + 1) idle();
        wr(2'd2, 32'hF);
        wr(2'd3, 32'hFF);
        set_in(4'h8);
        idle();
        idle();
        set_in(4'h0);
        repeat (S + 1) idle();
        rd_expect("masked_edge", 2'd2, 32'h8);
        chk("masked_irq", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h8);
        @(posedge clk);
        #1;
        chk("unmask_irq", {31'b0, irq}, 32'h1);

        // Simultaneous read and write of MASK
        cyc(1'b1, 1'b1, 2'd1, 32'hA);
        @(posedge clk);
        #1;
        chk("rw_old_mask", bus.readdata, 32'h8);
        rd_expect("rw_new_mask", 2'd1, 32'hA);

        // DATA is read-only
        set_in(4'h6);
        repeat (S + 1) idle();
        wr(2'd0, 32'hFFFF_FFFF);
        rd_expect("data_read", 2'd0, 32'h6);

        // Async reset mid read burst with all events pending
        wr(2'd1, 32'hF);
        set_in(4'hF);
        repeat (S + 1) idle();
        set_in(4'h0);
        repeat (S + 1) idle();
        rd_expect("pre_reset_edge", 2'd2, 32'hF);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        cyc(1'b1, 1'b0, 2'd2, 32'h0);
        cyc(1'b1, 1'b0, 2'd3, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        chk("async_rst_rdata", bus.readdata, 32'h0);
        bus.read = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        rd_expect("post_rst_edge", 2'd2, 32'h0);
        rd_expect("post_rst_mode", 2'd3, 32'h0);
        rd_expect("post_rst_mask", 2'd1, 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            bus.read = 1'($urandom);
            bus.write = ($urandom_range(0, 2) == 0);
            bus.address = 2'($urandom);
            bus.writedata = $urandom;
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
